// File: rtl/sensor_scanner.sv
// Sequential sensor scanner: requests a reading per channel, holds it for the change-detector
// co-processor, and raises an alert strobe on a matching change flag. Optional: SCAN_ALERT_COUNT_EN.
module sensor_scanner #(
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic       sample_req,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic [7:0] r0,
  output logic [1:0] check,
  input  logic       Q,
  input  logic [1:0] Q1,
  output logic       alert_valid,
  output logic [1:0] alert_ch,
  output logic [7:0] alert_data,
  output logic       busy
`ifdef SCAN_ALERT_COUNT_EN
  ,
  input  logic [1:0] count_sel,
  output logic [7:0] alert_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_CAPTURE,
    ST_NEXT
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_r0;
  logic [1:0] r_check;
  logic [7:0] r_wait_cnt;
  logic [3:0] r_hold_cnt;
  logic       r_alert_valid;
  logic [1:0] r_alert_ch;
  logic [7:0] r_alert_data;
  logic       w_alert;

  assign r0          = r_r0;
  assign check       = r_check;
  assign alert_valid = r_alert_valid;
  assign alert_ch    = r_alert_ch;
  assign alert_data  = r_alert_data;
  assign w_alert     = (r_state == ST_CAPTURE) && Q && (Q1 == r_check);

  always_comb begin
    w_next     = r_state;
    sample_req = 1'b0;
    busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) w_next = ST_REQ;
      end
      ST_REQ: begin
        sample_req = 1'b1;
        w_next     = ST_WAIT;
      end
      ST_WAIT: begin
        // a strobe on the final (255th) wait cycle still wins over the timeout
        if (sample_valid)              w_next = ST_HOLD;
        else if (r_wait_cnt == 8'd254) w_next = ST_NEXT;
      end
      ST_HOLD: begin
        if (r_hold_cnt <= 4'd1) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: w_next = ST_NEXT;
      ST_NEXT:    w_next = enable ? ST_REQ : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_r0          <= '0;
      r_check       <= '0;
      r_wait_cnt    <= '0;
      r_hold_cnt    <= '0;
      r_alert_valid <= 1'b0;
      r_alert_ch    <= '0;
      r_alert_data  <= '0;
    end else begin
      r_state       <= w_next;
      r_alert_valid <= w_alert;
      case (r_state)
        ST_REQ: r_wait_cnt <= '0;
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          if (sample_valid) begin
            r_r0       <= sample_data;
            r_hold_cnt <= 4'(HOLD_CYCLES);
          end
        end
        ST_HOLD: r_hold_cnt <= r_hold_cnt - 4'd1;
        ST_CAPTURE: begin
          if (w_alert) begin
            r_alert_ch   <= r_check;
            r_alert_data <= r_r0;
          end
        end
        ST_NEXT: r_check <= r_check + 2'd1;
        default: ;
      endcase
    end
  end

`ifdef SCAN_ALERT_COUNT_EN
  logic [7:0] r_alert_cnt [4];

  assign alert_count = r_alert_cnt[count_sel];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) r_alert_cnt[i] <= '0;
    end else if (w_alert && (r_alert_cnt[r_check] != 8'hFF)) begin
      r_alert_cnt[r_check] <= r_alert_cnt[r_check] + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_scanner.sv
// Directed bench for sensor_scanner: a table of per-channel scans plus hand-written
// reset-in-HOLD, enable-drop and (with SCAN_ALERT_COUNT_EN) counter saturation sequences.
module tb_sensor_scanner;

  logic       clk = 1'b0;
  logic       reset, enable, sample_valid, Q;
  logic [7:0] sample_data;
  logic [1:0] Q1;
  logic       sample_req, alert_valid, busy;
  logic [7:0] r0, alert_data;
  logic [1:0] check, alert_ch;
`ifdef SCAN_ALERT_COUNT_EN
  logic [1:0] count_sel;
  logic [7:0] alert_count;
`endif

  sensor_scanner #(.HOLD_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_req(sample_req), .sample_valid(sample_valid), .sample_data(sample_data),
    .r0(r0), .check(check), .Q(Q), .Q1(Q1),
    .alert_valid(alert_valid), .alert_ch(alert_ch), .alert_data(alert_data), .busy(busy)
`ifdef SCAN_ALERT_COUNT_EN
    , .count_sel(count_sel), .alert_count(alert_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_alert = 0;
  logic prev_av = 1'b0;

  logic [1:0] exp_check = '0;
  logic [7:0] exp_r0    = '0;
  logic [1:0] exp_ach   = '0;
  logic [7:0] exp_adata = '0;

  always @(negedge clk) begin
    if (alert_valid === 1'b1) begin
      n_chk++;
      if (prev_av === 1'b1) begin
        n_fail++;
        $display("FAIL alert_back_to_back: alert_valid=1 in two consecutive cycles, required single-cycle pulse");
      end
      n_alert++;
    end
    prev_av = alert_valid;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int k = 0;
    while (sample_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    chk("req_seen", sample_req, 1);
    chk("busy_scan", busy, 1);
  endtask

  // dly = k: sample_valid during the k-th WAIT cycle; dly = 0: never answer
  task automatic do_scan(input int dly, input logic [7:0] data, input logic q,
                         input logic [1:0] q1, input logic exp_al);
    int k;
    int a0;
    logic [1:0] cur;
    logic [1:0] nxt;
    Q = q; Q1 = q1; a0 = n_alert; cur = exp_check; nxt = exp_check + 2'd1;
    wait_req();
    @(negedge clk);
    chk("req_one_cycle", sample_req, 0);
    if (dly > 0) begin
      repeat (dly - 1) @(negedge clk);
      sample_valid = 1'b1; sample_data = data;
      @(negedge clk);
      sample_valid = 1'b1; sample_data = ~data;
      @(negedge clk);
      sample_valid = 1'b0;
      exp_r0 = data;
    end
    k = 0;
    while (check !== nxt && k < 400) begin @(negedge clk); k++; end
    chk("check_advance", check, nxt);
    exp_check = nxt;
    chk("alert_pulses", n_alert - a0, exp_al);
    if (exp_al) begin exp_ach = cur; exp_adata = data; end
    chk("alert_ch", alert_ch, exp_ach);
    chk("alert_data", alert_data, exp_adata);
    chk("r0", r0, exp_r0);
  endtask

  typedef struct {
    int         dly;
    logic [7:0] data;
    logic       q;
    logic [1:0] q1;
    logic       al;
  } vec_t;

  vec_t vt[10];

  initial begin
    int k;
    int a0;
    vt[0] = '{2,   8'h10, 1'b0, 2'd0, 1'b0};  // ch0
    vt[1] = '{2,   8'h10, 1'b0, 2'd0, 1'b0};  // ch1
    vt[2] = '{2,   8'h10, 1'b0, 2'd0, 1'b0};  // ch2
    vt[3] = '{2,   8'h10, 1'b0, 2'd0, 1'b0};  // ch3
    vt[4] = '{2,   8'h22, 1'b1, 2'd0, 1'b1};  // ch0 match
    vt[5] = '{3,   8'h33, 1'b1, 2'd2, 1'b0};  // ch1 mismatch
    vt[6] = '{2,   8'h40, 1'b1, 2'd2, 1'b1};  // ch2 match
    vt[7] = '{1,   8'h55, 1'b1, 2'd1, 1'b0};  // ch3 mismatch, wrap
    vt[8] = '{255, 8'h66, 1'b1, 2'd0, 1'b1};  // ch0 strobe on last WAIT cycle
    vt[9] = '{0,   8'h00, 1'b0, 2'd0, 1'b0};  // timeout after reset, ch0

    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_data = '0; Q = 1'b0; Q1 = '0;
`ifdef SCAN_ALERT_COUNT_EN
    count_sel = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_sample_req", sample_req, 0);
    chk("rst_r0", r0, 0);
    chk("rst_check", check, 0);
    chk("rst_alert_valid", alert_valid, 0);
    chk("rst_alert_ch", alert_ch, 0);
    chk("rst_alert_data", alert_data, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_no_req", sample_req, 0);
    enable = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        // reset lands mid-HOLD on channel 1
        Q = 1'b1; Q1 = 2'd1;
        wait_req();
        @(negedge clk);
        sample_valid = 1'b1; sample_data = 8'h77;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        chk("hold_r0", r0, 8'h77);
        chk("hold_check", check, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("hrst_sample_req", sample_req, 0);
        chk("hrst_r0", r0, 0);
        chk("hrst_check", check, 0);
        chk("hrst_alert_valid", alert_valid, 0);
        chk("hrst_alert_ch", alert_ch, 0);
        chk("hrst_alert_data", alert_data, 0);
        chk("hrst_busy", busy, 0);
        reset = 1'b0;
        exp_check = '0; exp_r0 = '0; exp_ach = '0; exp_adata = '0;
      end
      do_scan(vt[i].dly, vt[i].data, vt[i].q, vt[i].q1, vt[i].al);
    end

`ifdef SCAN_ALERT_COUNT_EN
    begin
      int exp_ch0 = 0;
      logic al;
      for (int s = 0; s < 4; s++) begin
        count_sel = 2'(s);
        #1 chk("cnt_post_reset", alert_count, 0);
      end
      while (exp_ch0 < 300) begin
        al = (exp_check == 2'd0);
        do_scan(1, 8'(exp_ch0), 1'b1, 2'd0, al);
        if (al) exp_ch0++;
      end
      for (int s = 0; s < 4; s++) begin
        count_sel = 2'(s);
        #1 chk("cnt_saturate", alert_count, (s == 0) ? 255 : 0);
      end
    end
`endif

    // enable dropped mid-HOLD: channel completes with its alert, then IDLE
    Q = 1'b1; Q1 = exp_check; a0 = n_alert;
    wait_req();
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 8'h99;
    @(negedge clk);
    sample_valid = 1'b0; enable = 1'b0;
    k = 0;
    while (busy !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    chk("stop_busy", busy, 0);
    chk("stop_alert_pulses", n_alert - a0, 1);
    chk("stop_alert_ch", alert_ch, exp_check);
    chk("stop_alert_data", alert_data, 8'h99);
    chk("stop_check", check, exp_check + 2'd1);
    k = 0;
    repeat (10) begin @(negedge clk); if (sample_req !== 1'b0 || busy !== 1'b0) k++; end
    chk("stop_stays_idle", k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
